// File: rtl/amm_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : amm_mem_responder
// Brief    : Avalon-MM memory slave with byte-enabled burst writes and fixed-
//            latency burst reads. Optional: MEM_RESP_ERR_INJECT_EN (bit-0 flip).
// Revision : 1.0
// ============================================================================
module amm_mem_responder #(
    parameter int AMM_ADDR_W  = 31,
    parameter int AMM_DATA_W  = 128,
    parameter int AMM_BURST_W = 11,
    parameter int DEPTH_W     = 10,
    parameter int RD_LATENCY  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic [AMM_ADDR_W-1:0]     address_i,
    input  logic                      read_i,
    input  logic                      write_i,
    input  logic [AMM_DATA_W-1:0]     writedata_i,
    input  logic [AMM_BURST_W-1:0]    burstcount_i,
    input  logic [AMM_DATA_W/8-1:0]   byteenable_i,
`ifdef MEM_RESP_ERR_INJECT_EN
    input  logic                      inj_en_i,
    input  logic [DEPTH_W-1:0]        inj_addr_i,
`endif
    output logic                      waitrequest_o,
    output logic                      readdatavalid_o,
    output logic [AMM_DATA_W-1:0]     readdata_o,
    output logic                      err_o
);

    localparam int DATA_B_W = AMM_DATA_W / 8;
    localparam int DEPTH    = 1 << DEPTH_W;
    localparam logic [RD_LATENCY-1:0] OUT_STAGE = RD_LATENCY'(1) << (RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [AMM_DATA_W-1:0]  mem [DEPTH];
    logic                   rst_hold;
    logic [DEPTH_W-1:0]     wr_addr;
    logic [DEPTH_W-1:0]     rd_addr;
    logic [DEPTH_W-1:0]     mem_wr_addr;
    logic [AMM_BURST_W-1:0] wr_rem;
    logic [AMM_BURST_W-1:0] rd_rem;
    logic [AMM_BURST_W-1:0] first_len;
    logic [RD_LATENCY-1:0]  vld;
    logic [AMM_DATA_W-1:0]  pipe [RD_LATENCY];
    logic                   accept;
    logic                   wr_fire;
    logic                   rd_start;
    logic                   rd_issue;
    logic                   err_set;
    logic [AMM_DATA_W-1:0]  rd_word;
    logic                   unused_addr;

    assign unused_addr   = ^address_i[AMM_ADDR_W-1:DEPTH_W];
    assign waitrequest_o = stall_i | (state == RD_BURST) | rst_hold;
    assign accept        = (read_i | write_i) & ~waitrequest_o;
    assign first_len     = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
    // waitrequest is always high in RD_BURST, so a fire here is IDLE or WR_BURST
    assign wr_fire       = write_i & ~waitrequest_o;
    assign rd_start      = (state == IDLE) & accept & ~write_i;
    assign rd_issue      = (state == RD_BURST) & (rd_rem != '0);
    assign mem_wr_addr   = (state == IDLE) ? address_i[DEPTH_W-1:0] : wr_addr;

`ifdef MEM_RESP_ERR_INJECT_EN
    assign rd_word = mem[rd_addr] ^ {{(AMM_DATA_W-1){1'b0}}, (inj_en_i && (rd_addr == inj_addr_i))};
`else
    assign rd_word = mem[rd_addr];
`endif

    always_comb begin
        err_set = 1'b0;
        if ((state == IDLE) && accept) begin
            if (read_i && write_i)
                err_set = 1'b1;
            if (burstcount_i == '0)
                err_set = 1'b1;
        end
        if ((state == WR_BURST) && read_i)
            err_set = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_fire) begin
                    if (first_len != AMM_BURST_W'(1))
                        state_nxt = WR_BURST;
                end else if (rd_start) begin
                    state_nxt = RD_BURST;
                end
            end
            WR_BURST: begin
                if (wr_fire && (wr_rem == AMM_BURST_W'(1)))
                    state_nxt = IDLE;
            end
            // leave once all reads are issued and only the last beat remains in flight
            RD_BURST: begin
                if ((rd_rem == '0) && ((vld & ~OUT_STAGE) == '0))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            rst_hold <= 1'b1;
            err_o    <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            wr_rem   <= '0;
            rd_rem   <= '0;
        end else begin
            state    <= state_nxt;
            rst_hold <= 1'b0;
            if (err_set)
                err_o <= 1'b1;
            if (wr_fire) begin
                wr_addr <= mem_wr_addr + 1'b1;
                wr_rem  <= (state == IDLE) ? first_len - 1'b1 : wr_rem - 1'b1;
            end
            if (rd_start) begin
                rd_addr <= address_i[DEPTH_W-1:0];
                rd_rem  <= first_len;
            end else if (rd_issue) begin
                rd_addr <= rd_addr + 1'b1;
                rd_rem  <= rd_rem - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            vld[0]  <= rd_issue;
            pipe[0] <= rd_word;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i]  <= vld[i-1];
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            for (int b = 0; b < DATA_B_W; b++) begin
                if (byteenable_i[b])
                    mem[mem_wr_addr][b*8 +: 8] <= writedata_i[b*8 +: 8];
            end
        end
    end

    assign readdatavalid_o = vld[RD_LATENCY-1];
    assign readdata_o      = pipe[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: doc/amm_mem_responder.md
# amm_mem_responder

Synthesizable Avalon-MM slave that answers the memory-side traffic issued by the memory checker: it accepts single and burst writes with byte enables, stores them in an internal array, and returns burst reads with a fixed, parameterized read latency. It sits on the mem-clock side in place of a real memory controller, so the checker can be exercised in simulation and on FPGA without external memory.

## Interface
- AMM_ADDR_W, 31: word address width, same as the checker's memory port.
- AMM_DATA_W, 128: data width; byte lanes = AMM_DATA_W/8 (DATA_B_W).
- AMM_BURST_W, 11: burstcount width.
- DEPTH_W, 10: storage depth is 2**DEPTH_W words; only address[DEPTH_W-1:0] is used.
- RD_LATENCY, 4: cycles from read acceptance to first readdatavalid; legal range 1..16.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_i  in  1  external back-pressure; forces waitrequest_o high.
- address_i  in  AMM_ADDR_W  word address of burst start.
- read_i  in  1  read command.
- write_i  in  1  write command/beat.
- writedata_i  in  AMM_DATA_W  write beat data.
- burstcount_i  in  AMM_BURST_W  burst length, sampled on the first beat only.
- byteenable_i  in  DATA_B_W  per-byte write enable, sampled every write beat.
- waitrequest_o  out  1  command/beat not accepted this cycle.
- readdatavalid_o  out  1  readdata_o valid.
- readdata_o  out  AMM_DATA_W  read beat data.
- err_o  out  1  sticky protocol-error flag, cleared only by reset.

## Operation
- Transfer accepted in a cycle iff (read_i or write_i) and waitrequest_o low.
- waitrequest_o = stall_i OR (state == RD_BURST) OR reset-hold; it is combinational in stall_i and registered otherwise.
- States: IDLE, WR_BURST, RD_BURST.
- IDLE, accepted write: beat 0 written to mem[address_i[DEPTH_W-1:0]] with byte lanes gated by byteenable_i; len = burstcount_i; if len == 1 stay IDLE, else latch addr+1, remaining = len-1, go WR_BURST.
- WR_BURST: each accepted write writes at current addr, addr increments, remaining decrements; remaining reaching 0 -> IDLE. address_i and burstcount_i are ignored during the burst.
- IDLE, accepted read: latch addr and len, go RD_BURST. One array word is read per cycle for len cycles, then the state holds until the final beat has left the latency pipeline, then -> IDLE.
- Read and write asserted together in IDLE: the write wins, and err_o is set.
- read_i asserted in WR_BURST: ignored, and err_o is set.
- burstcount_i == 0 on a first beat: treated as 1, and err_o is set.
- Address increments modulo 2**DEPTH_W, so bursts wrap to word 0.
- Array contents are not reset. Reads of never-written words return whatever the array holds.

## Timing
- Read accepted at edge n: beat k is valid on readdatavalid_o at edge n+RD_LATENCY+k, for k = 0..len-1, back-to-back with no gaps.
- waitrequest_o is high from edge n+1 through the last-beat cycle, and low in the following cycle (absent stall_i).
- A write beat is visible to a read accepted at the next edge; read-after-write returns the new data.
- Write throughput is 1 beat/cycle. stall_i inserts gaps and never drops a beat.
- Reset values: waitrequest_o = 1, readdatavalid_o = 0, readdata_o = 0, err_o = 0, state = IDLE.
- waitrequest_o falls at the first clk_i edge after rst_i deasserts.
- Reset mid-burst aborts the burst and flushes the read pipeline, so no further readdatavalid_o is produced. Writes already performed persist.

## Configuration
- MEM_RESP_ERR_INJECT_EN defined: adds ports inj_en_i (in, 1) and inj_addr_i (in, DEPTH_W). Any read beat whose array address equals inj_addr_i while inj_en_i = 1 returns stored data with bit 0 inverted. Stored data is unchanged.
- Macro undefined: ports absent, read data is always the stored data, no added logic.

## Test plan
- Write 0xA5..A5 to address 0x10 (burst 1, all byteenables), then read 0x10, RD_LATENCY = 4 -> readdatavalid_o high exactly 4 cycles after acceptance with 0xA5..A5; waitrequest_o low again the next cycle.
- Burst write 8 beats of data = index at 0x20, then burst read 8 -> 8 consecutive valid beats returning 0..7, and err_o = 0.
- Write all-ones, then write zeros with byteenable = 0x0001 -> read returns all-ones except byte 0 = 0x00.
- DEPTH_W = 4: burst write 4 at address 0xE -> words 0xE, 0xF, 0x0, 0x1 written; read 4 from 0xE returns the same sequence.
- Toggle stall_i randomly during a 16-beat write, then read back -> all 16 beats correct. Separately, issue burstcount 0 and read during WR_BURST -> err_o sets and stays 1 until rst_i.
- Assert rst_i at the 3rd beat of an 8-beat read -> readdatavalid_o drops to 0 immediately and stays 0. With MEM_RESP_ERR_INJECT_EN, inj_addr_i = 0x10 -> bit 0 of the read data from 0x10 is inverted.
